// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg
//   Shared constants for the 5-stage MIPS stall controller. The instruction
//   decoder that drives the hazard unit's d_* inputs uses the same Tuse/Tnew
//   encodings, so both sides agree on what "cycles until needed" and
//   "cycles until produced" mean.
//
//   Contents:
//     TUSE_*           cycles (from D) until a source operand is consumed
//     TNEW_*           cycles (from E) until a result becomes forwardable
//     MULT/DIV_CYCLES  default multiply/divide unit occupancy
//     md_op_e          which busy count the multiply/divide counter loads
//     max_int          helper used to size the busy counter
// ---------------------------------------------------------------------------
package hazard_unit_pkg;

   // Tuse: how many cycles after D the operand is actually needed
   localparam int TUSE_BRANCH   = 0;   // branch compare / jr in D
   localparam int TUSE_CALC     = 1;   // ALU operand in E
   localparam int TUSE_STORE_RT = 2;   // store data consumed in M

   // Tnew: how many cycles after E the result is produced
   localparam int TNEW_LOAD = 2;       // available after M
   localparam int TNEW_CALC = 1;       // available after E
   localparam int TNEW_NONE = 0;       // jal link value, already known

   // Default multiply/divide busy durations after the op leaves E
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      MD_OP_MULT = 1'b0,
      MD_OP_DIV  = 1'b1
   } md_op_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_unit_md_busy_ctr.sv
// ---------------------------------------------------------------------------
// md_busy_ctr
//   Multiply/divide occupancy counter. When a mult/div leaves E the counter
//   is loaded with the unit latency and then counts down to zero; md_busy is
//   high while it is nonzero. A load always wins over the decrement, so
//   back-to-back multiply/divide ops restart the count cleanly.
//
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   asynchronous, active-high; clears the count
//     load      in   a mult/div is leaving E on this edge
//     load_div  in   qualifies load: 1 = divide latency, 0 = multiply
//     md_busy   out  counter nonzero
//
//   MULT_CYCLES and DIV_CYCLES are expected to be at least 1.
// ---------------------------------------------------------------------------
module md_busy_ctr
   import hazard_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic load_div,
   output logic md_busy
);

   localparam int CNT_MAX = max_int(MULT_CYCLES, DIV_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   logic [CW-1:0] md_cnt;
   logic [CW-1:0] md_cnt_next;
   md_op_e        load_op;

   assign load_op = load_div ? MD_OP_DIV : MD_OP_MULT;

   always_comb begin
      md_cnt_next = md_cnt;
      if (load) begin
         md_cnt_next = (load_op == MD_OP_DIV) ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt != '0) begin
         md_cnt_next = md_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= '0;
      end else begin
         md_cnt <= md_cnt_next;
      end
   end

   // Driven straight from the register, so an asynchronous reset drops it
   // without waiting for a clock edge.
   assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Stall controller for the 5-stage MIPS pipeline. Instead of re-decoding
//   the instructions in E and M, it keeps a small registered scoreboard of
//   {dest, write-enable, Tnew} for those two stages, fed from the D-stage
//   decode, and ages Tnew as instructions move on. W always has Tnew = 0
//   and is handled by forwarding, so it is not tracked.
//
//   A D instruction stalls when a source it reads is produced by E or M
//   later than it is needed (Tuse < Tnew), or when it touches HI/LO while the
//   multiply/divide unit is busy (or a mult/div is sitting in E about to
//   start it). On a stall the unit inserts its own bubble into the E entry.
//
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   asynchronous, active-high
//     d_rs_addr    in   D-stage rs
//     d_rt_addr    in   D-stage rt
//     d_rs_rd      in   D instruction reads rs
//     d_rt_rd      in   D instruction reads rt
//     d_tuse_rs    in   cycles until rs is needed
//     d_tuse_rt    in   cycles until rt is needed
//     d_we         in   D instruction writes the GRF
//     d_a3         in   D destination register
//     d_tnew       in   Tnew the instruction will have in E
//     d_md_start   in   D instruction is mult/multu/div/divu
//     d_md_div     in   qualifies d_md_start: 1 = divide
//     d_md_use     in   D instruction uses the multiply/divide unit or HI/LO
//     stall        out  hold PC and F/D; bubble into D/E
//     md_busy      out  multiply/divide counter nonzero
// ---------------------------------------------------------------------------
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int TW          = 2,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] d_rs_addr,
   input  logic [REG_AW-1:0] d_rt_addr,
   input  logic              d_rs_rd,
   input  logic              d_rt_rd,
   input  logic [TW-1:0]     d_tuse_rs,
   input  logic [TW-1:0]     d_tuse_rt,
   input  logic              d_we,
   input  logic [REG_AW-1:0] d_a3,
   input  logic [TW-1:0]     d_tnew,
   input  logic              d_md_start,
   input  logic              d_md_div,
   input  logic              d_md_use,
   output logic              stall,
   output logic              md_busy
);

   localparam int NSRC = 2;   // index 0 = rs, 1 = rt

   // Saturating decrement: a result that is already available stays so.
   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : (t - TW'(1));
   endfunction

   // ---------------- scoreboard state ----------------
   logic [REG_AW-1:0] e_a3;
   logic              e_we;
   logic [TW-1:0]     e_tnew;
   logic              e_md_start;
   logic              e_md_div;

   logic [REG_AW-1:0] m_a3;
   logic              m_we;
   logic [TW-1:0]     m_tnew;

   // ---------------- hazard detection ----------------
   logic [REG_AW-1:0] src_addr [NSRC];
   logic              src_rd   [NSRC];
   logic [TW-1:0]     src_tuse [NSRC];
   logic [NSRC-1:0]   stall_src;
   logic              stall_md;

   assign src_addr[0] = d_rs_addr;
   assign src_addr[1] = d_rt_addr;
   assign src_rd[0]   = d_rs_rd;
   assign src_rd[1]   = d_rt_rd;
   assign src_tuse[0] = d_tuse_rs;
   assign src_tuse[1] = d_tuse_rt;

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         logic hit_e;
         logic hit_m;

         // Producer matches and will not have the value ready in time.
         assign hit_e = e_we && (e_a3 == src_addr[gi]) && (src_tuse[gi] < e_tnew);
         assign hit_m = m_we && (m_a3 == src_addr[gi]) && (src_tuse[gi] < m_tnew);

         assign stall_src[gi] = src_rd[gi] && (src_addr[gi] != '0) && (hit_e || hit_m);
      end
   endgenerate

   // A mult/div still in E has not loaded the counter yet, so it must block
   // HI/LO users on its own.
   assign stall_md = d_md_use && (md_busy || e_md_start);

   assign stall = (|stall_src) || stall_md;

   // ---------------- scoreboard advance ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_a3       <= '0;
         e_we       <= 1'b0;
         e_tnew     <= '0;
         e_md_start <= 1'b0;
         e_md_div   <= 1'b0;
         m_a3       <= '0;
         m_we       <= 1'b0;
         m_tnew     <= '0;
      end else begin
         if (stall) begin
            // Bubble: nothing written, no multiply/divide start.
            e_a3       <= '0;
            e_we       <= 1'b0;
            e_tnew     <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
         end else begin
            e_a3       <= d_a3;
            // Writes to the zero register never create a dependency.
            e_we       <= d_we && (d_a3 != '0);
            e_tnew     <= d_tnew;
            e_md_start <= d_md_start;
            e_md_div   <= d_md_div;
         end
         m_a3   <= e_a3;
         m_we   <= e_we;
         m_tnew <= sat_dec(e_tnew);
      end
   end

   // ---------------- multiply/divide occupancy ----------------
   // The counter loads from the E entry, which is all-zero for a bubble,
   // so a bubble can never start it.
   md_busy_ctr #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (e_md_start),
      .load_div (e_md_div),
      .md_busy  (md_busy)
   );

endmodule
